matmul_sequencer: RTL and testbench

- Sequences one N×N matrix product through the shared 16-bit multiply-accumulate path and its feedback/accumulate gate.
- Generates operand-memory read addresses for A (row-major) and B (row-major), MAC enables, and accumulator clear/last strobes for each dot product.
- Presents each finished C[i][j] through a valid/ready handshake.
- Sits between the operand buffers and the result writer; one product per start.

---
 rtl/matmul_sequencer.sv | 126 ++++++++++++
 tb/tb_matmul_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Sequences one NxN matrix product (row-major A and B) through a shared MAC.
// Optional stall counter output enabled by defining MATMUL_SEQ_STALL_CNT_EN.
module matmul_sequencer #(
  parameter int N       = 3,
  parameter int ADDR_W  = 4,
  parameter int IDX_W   = 2,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              mac_en,
  output logic              acc_clr,
  output logic              acc_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  res_row,
  output logic [IDX_W-1:0]  res_col
`ifdef MATMUL_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, RESULT, DONE} state_t;

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_t           state;
  logic [IDX_W-1:0] i, j, k;
  logic [DW-1:0]    dcnt;
  logic             k_first, k_last, kill;

  assign k_first = (k == '0);
  assign k_last  = (k == IDX_W'(N-1));
  assign kill    = abort && (state != IDLE);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign rd_en     = (state == ISSUE);
  assign res_valid = (state == RESULT);
  assign a_addr    = rd_en ? ADDR_W'(32'(i) * N + 32'(k)) : '0;
  assign b_addr    = rd_en ? ADDR_W'(32'(k) * N + 32'(j)) : '0;
  assign res_row   = res_valid ? i : '0;
  assign res_col   = res_valid ? j : '0;

  always_ff @(posedge clk) begin
    if (aclr) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      dcnt     <= '0;
      mac_en   <= 1'b0;
      acc_clr  <= 1'b0;
      acc_last <= 1'b0;
    end else begin
      // Term flags trail the read by the fixed one-cycle memory latency;
      // an abort flushes them so the MAC never sees a stray enable.
      mac_en   <= rd_en && !kill;
      acc_clr  <= rd_en && k_first && !kill;
      acc_last <= rd_en && k_last && !kill;
      if (kill) begin
        state <= IDLE;
        i     <= '0;
        j     <= '0;
        k     <= '0;
        dcnt  <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state <= ISSUE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
          end
          ISSUE: if (k_last) begin
            k     <= '0;
            dcnt  <= '0;
            state <= DRAIN;
          end else begin
            k <= k + IDX_W'(1);
          end
          DRAIN: if (dcnt == DW'(MAC_LAT-1)) state <= RESULT;
                 else dcnt <= dcnt + DW'(1);
          RESULT: if (res_ready) begin
            if (32'(j) < N-1) begin
              j     <= j + IDX_W'(1);
              state <= ISSUE;
            end else if (32'(i) < N-1) begin
              j     <= '0;
              i     <= i + IDX_W'(1);
              state <= ISSUE;
            end else begin
              state <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef MATMUL_SEQ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (aclr)
      stall_cycles <= '0;
    else if (state == IDLE && start)
      stall_cycles <= '0;
    else if (res_valid && !res_ready && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: N=3 main instance plus an N=1 instance.
module tb_matmul_sequencer;
  localparam int N = 3, AW = 4, IW = 2, ML = 1;

  logic clk = 1'b0;
  logic aclr, start, abort, res_ready;
  logic busy, done, rd_en, mac_en, acc_clr, acc_last, res_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [IW-1:0] res_row, res_col;
`ifdef MATMUL_SEQ_STALL_CNT_EN
  logic [15:0] stall_cycles, u_stall;
`endif

  logic u_start, u_abort, u_rdy;
  logic u_busy, u_done, u_rd, u_mac, u_clr, u_last, u_rv;
  logic [0:0] u_a, u_b, u_row, u_col;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  matmul_sequencer #(.N(N), .ADDR_W(AW), .IDX_W(IW), .MAC_LAT(ML)) dut (
    .clk(clk), .aclr(aclr), .start(start), .abort(abort), .busy(busy), .done(done),
    .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr), .mac_en(mac_en),
    .acc_clr(acc_clr), .acc_last(acc_last), .res_valid(res_valid),
    .res_ready(res_ready), .res_row(res_row), .res_col(res_col)
`ifdef MATMUL_SEQ_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  matmul_sequencer #(.N(1), .ADDR_W(1), .IDX_W(1), .MAC_LAT(1)) dut1 (
    .clk(clk), .aclr(aclr), .start(u_start), .abort(u_abort), .busy(u_busy), .done(u_done),
    .rd_en(u_rd), .a_addr(u_a), .b_addr(u_b), .mac_en(u_mac),
    .acc_clr(u_clr), .acc_last(u_last), .res_valid(u_rv),
    .res_ready(u_rdy), .res_row(u_row), .res_col(u_col)
`ifdef MATMUL_SEQ_STALL_CNT_EN
    , .stall_cycles(u_stall)
`endif
  );

  typedef struct { int a; int b; } addr_t;
  typedef struct { int clr; int last; } flag_t;
  typedef struct { int r; int c; } res_t;
  addr_t aq[$];
  flag_t fq[$];
  res_t  rq[$];

  int total = 0, bad = 0;
  int done_cnt = 0, done_cyc = -1, first_rv = -1, t0 = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every (i,j) in row-major order, each with N terms k = 0..N-1.
  task automatic push_product();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        rq.push_back('{i, j});
        for (int k = 0; k < N; k++) begin
          aq.push_back('{i*N + k, k*N + j});
          fq.push_back('{int'(k == 0), int'(k == N-1)});
        end
      end
  endtask

  task automatic flush_model();
    aq.delete(); fq.delete(); rq.delete();
  endtask

  // Monitor: samples on the falling edge, well away from input changes.
  logic hold_v = 1'b0, acc_prev = 1'b0;
  int   hold_r, hold_c;
  always @(negedge clk) begin
    addr_t ea; flag_t ef; res_t er;
    if (aclr) begin
      hold_v = 1'b0; acc_prev = 1'b0;
    end else begin
      if (rd_en) begin
        if (aq.size() == 0) chk("rd_spurious", 1, 0);
        else begin
          ea = aq.pop_front();
          chk("a_addr", int'(a_addr), ea.a);
          chk("b_addr", int'(b_addr), ea.b);
        end
      end else chk("addr_idle", int'(a_addr) + int'(b_addr), 0);
      if (mac_en) begin
        if (fq.size() == 0) chk("mac_spurious", 1, 0);
        else begin
          ef = fq.pop_front();
          chk("acc_clr", int'(acc_clr), ef.clr);
          chk("acc_last", int'(acc_last), ef.last);
        end
      end else chk("flag_idle", int'(acc_clr | acc_last), 0);
      if (acc_prev) begin
        if (rq.size() > 0) chk("resume_rd", int'(rd_en), 1);
        else chk("done_after_last", int'(done), 1);
      end
      chk("rd_during_res", int'(rd_en & res_valid), 0);
      if (res_valid) begin
        if (first_rv < 0) first_rv = cyc;
        if (hold_v) begin
          chk("hold_row", int'(res_row), hold_r);
          chk("hold_col", int'(res_col), hold_c);
        end
        if (res_ready) begin
          if (rq.size() == 0) chk("res_spurious", 1, 0);
          else begin
            er = rq.pop_front();
            chk("res_row", int'(res_row), er.r);
            chk("res_col", int'(res_col), er.c);
          end
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1; hold_r = int'(res_row); hold_c = int'(res_col);
        end
      end else begin
        chk("rowcol_idle", int'(res_row) + int'(res_col), 0);
        hold_v = 1'b0;
      end
      acc_prev = res_valid & res_ready;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_start();
    tick();
    start = 1'b1; t0 = cyc; first_rv = -1;
    push_product();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin tick(); n++; end
    chk("done_timeout", int'(done_cnt >= target), 1);
  endtask

  initial begin
    int dc;
    bit seen;
    aclr = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    u_start = 1'b0; u_abort = 1'b0; u_rdy = 1'b1;
    repeat (2) tick();
    aclr = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd", int'(rd_en), 0);
    chk("rst_mac", int'(mac_en | acc_clr | acc_last), 0);
    chk("rst_res", int'(res_valid | done), 0);
    chk("rst_n1_busy", int'(u_busy), 0);

    // Full product, ready held high
    do_start();
    chk("first_rd", int'(rd_en), 1);
    wait_done(200, 1);
    chk("done_cycle", done_cyc - t0, 46);
    chk("first_rv_cycle", first_rv - t0, 5);
    repeat (3) tick();
    chk("single_done", done_cnt, 1);
    chk("idle_after", int'(busy), 0);

    // Backpressure on C[1][2]
    do_start();
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      if (res_valid && res_row == 2'd1 && res_col == 2'd2) seen = 1;
      else tick();
    end
    chk("saw_c12", int'(seen), 1);
    res_ready = 1'b0;
    repeat (4) tick();
    res_ready = 1'b1;
    wait_done(200, 2);
`ifdef MATMUL_SEQ_STALL_CNT_EN
    chk("stall_cycles", int'(stall_cycles), 4);
`endif

    // Abort in the second ISSUE cycle of C[2][0]
    do_start();
    repeat (31) tick();
    chk("abort_pt_a", int'(a_addr), 7);
    chk("abort_pt_b", int'(b_addr), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_rd", int'(rd_en), 0);
    chk("abort_mac", int'(mac_en), 0);
    flush_model();
    dc = done_cnt;
    repeat (10) tick();
    chk("abort_no_done", done_cnt, dc);
    do_start();
    wait_done(200, dc + 1);

    // Random backpressure with ignored start pulses in RESULT and DONE
    for (int r = 0; r < 2; r++) begin
      dc = done_cnt;
      do_start();
      seen = 0;
      for (int n = 0; n < 3000 && !seen; n++) begin
        if (done) begin
          seen = 1; start = 1'b1; tick(); start = 1'b0;
        end else begin
          res_ready = 1'($urandom_range(0, 1));
          start = res_valid ? 1'($urandom_range(0, 1)) : 1'b0;
          tick();
        end
      end
      start = 1'b0; res_ready = 1'b1;
      chk("rand_done_seen", int'(seen), 1);
      repeat (5) tick();
      chk("rand_idle", int'(busy), 0);
      chk("rand_done_cnt", done_cnt, dc + 1);
      chk("rand_rq_empty", rq.size(), 0);
      chk("rand_aq_empty", aq.size(), 0);
    end

    // Reset mid-ISSUE
    do_start();
    tick();
    aclr = 1'b1;
    repeat (2) tick();
    aclr = 1'b0;
    flush_model();
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_rd", int'(rd_en) + int'(a_addr) + int'(b_addr), 0);
    chk("rst2_mac", int'(mac_en | acc_clr | acc_last), 0);
    dc = done_cnt;
    do_start();
    wait_done(200, dc + 1);

    // N=1 instance
    tick();
    u_start = 1'b1;
    tick();
    u_start = 1'b0;
    chk("n1_rd", int'(u_rd), 1);
    chk("n1_addr", int'(u_a) + int'(u_b), 0);
    chk("n1_mac_early", int'(u_mac), 0);
    tick();
    chk("n1_mac", int'(u_mac), 1);
    chk("n1_clr", int'(u_clr), 1);
    chk("n1_last", int'(u_last), 1);
    chk("n1_rd_off", int'(u_rd), 0);
    tick();
    chk("n1_rv", int'(u_rv), 1);
    tick();
    chk("n1_done", int'(u_done), 1);
    tick();
    chk("n1_idle", int'(u_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
